// File: rtl/axi_sched_pkg.sv
// Shared types and the round-robin pick helper for the AXI master scheduler.
package axi_sched_pkg;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t StIdle  = 1'b0;
  localparam arb_state_t StGrant = 1'b1;

  localparam int unsigned RrMaxN = 64;
  localparam int unsigned RrIdxW = 6;

  typedef struct packed {
    logic              found;
    logic [RrIdxW-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping modulo n (n is a power of two).
  function automatic rr_pick_t rr_pick(input logic [RrMaxN-1:0] req,
                                       input logic [RrIdxW-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t          res;
    logic [RrIdxW-1:0] k;
    res = '0;
    for (int unsigned i = 0; i < RrMaxN; i++) begin
      k = RrIdxW'((32'(ptr) + i) & (n - 1));
      if (i < n && !res.found && req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_rr_addr_arb.sv
// Round-robin address-channel arbiter: registered grant held until the handshake.
module axi_rr_addr_arb
  import axi_sched_pkg::*;
#(
  parameter int unsigned M_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [(2**M_WIDTH)-1:0]   req,
  input  logic                      ready,
  input  logic                      block,
  output logic [M_WIDTH-1:0]        sel,
  output logic                      grant,
  output logic                      handshake
);

  localparam int unsigned N = 2 ** M_WIDTH;

  arb_state_t         state_q, state_d;
  logic [M_WIDTH-1:0] sel_q, sel_d;
  logic [M_WIDTH-1:0] ptr_q, ptr_d;
  rr_pick_t           pick;

  always_comb pick = rr_pick(RrMaxN'(req), RrIdxW'(ptr_q), N);

  assign handshake = (state_q == StGrant) && req[sel_q] && ready;
  assign grant     = (state_q == StGrant);
  assign sel       = sel_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (state_q == StIdle) begin
      if (pick.found && !block) begin
        state_d = StGrant;
        sel_d   = M_WIDTH'(pick.idx);
      end
    end else if (handshake) begin
      // Once granted, stay put even if the master drops VALID.
      state_d = StIdle;
      ptr_d   = sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/axi_rr_master_scheduler.sv
// AXI4 round-robin master scheduler: AW/AR arbiters plus in-order W-grant FIFO.
module axi_rr_master_scheduler
  import axi_sched_pkg::*;
#(
  parameter int unsigned M_WIDTH = 2,
  parameter int unsigned WQ_AW   = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [(2**M_WIDTH)-1:0] MASTER_WR_ADDR_VALID,
  input  logic [(2**M_WIDTH)-1:0] MASTER_RD_ADDR_VALID,
  input  logic                    BUS_WR_ADDR_READY,
  input  logic                    BUS_WR_DATA_VALID,
  input  logic                    BUS_WR_DATA_READY,
  input  logic                    BUS_WR_DATA_LAST,
  input  logic                    BUS_RD_ADDR_READY,
  output logic [M_WIDTH-1:0]      wr_addr_master_sel,
  output logic                    wr_addr_grant,
  output logic [M_WIDTH-1:0]      wr_data_master_sel,
  output logic                    wr_data_grant,
  output logic [M_WIDTH-1:0]      rd_addr_master_sel,
  output logic                    rd_addr_grant,
  output logic                    wq_full
);

  localparam int unsigned D = 2 ** WQ_AW;

  logic aw_handshake;
  logic ar_handshake;

  axi_rr_addr_arb #(
    .M_WIDTH(M_WIDTH)
  ) u_aw_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (MASTER_WR_ADDR_VALID),
    .ready    (BUS_WR_ADDR_READY),
    .block    (wq_full),
    .sel      (wr_addr_master_sel),
    .grant    (wr_addr_grant),
    .handshake(aw_handshake)
  );

  axi_rr_addr_arb #(
    .M_WIDTH(M_WIDTH)
  ) u_ar_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (MASTER_RD_ADDR_VALID),
    .ready    (BUS_RD_ADDR_READY),
    .block    (1'b0),
    .sel      (rd_addr_master_sel),
    .grant    (rd_addr_grant),
    .handshake(ar_handshake)
  );

  logic [M_WIDTH-1:0] wq_mem [D];
  logic [WQ_AW-1:0]   wq_wptr_q;
  logic [WQ_AW-1:0]   wq_rptr_q;
  logic [WQ_AW:0]     wq_cnt_q;
  logic               wq_push;
  logic               wq_pop;

  // The arbiter never leaves IDLE while full, so a push always has room.
  assign wq_push = aw_handshake;
  assign wq_pop  = BUS_WR_DATA_VALID && BUS_WR_DATA_READY && BUS_WR_DATA_LAST && wr_data_grant;

  assign wr_data_grant      = (wq_cnt_q != '0);
  assign wr_data_master_sel = wq_mem[wq_rptr_q];
  assign wq_full            = (wq_cnt_q == (WQ_AW + 1)'(D));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < D; i++) begin
        wq_mem[i] <= '0;
      end
      wq_wptr_q <= '0;
      wq_rptr_q <= '0;
      wq_cnt_q  <= '0;
    end else begin
      if (wq_push) begin
        wq_mem[wq_wptr_q] <= wr_addr_master_sel;
        wq_wptr_q         <= wq_wptr_q + 1'b1;
      end
      if (wq_pop) begin
        wq_rptr_q <= wq_rptr_q + 1'b1;
      end
      if (wq_push && !wq_pop) begin
        wq_cnt_q <= wq_cnt_q + 1'b1;
      end else if (!wq_push && wq_pop) begin
        wq_cnt_q <= wq_cnt_q - 1'b1;
      end
    end
  end

  logic unused_ar_handshake;
  assign unused_ar_handshake = ar_handshake;

endmodule

// File: tb/tb_axi_rr_master_scheduler.sv
// Randomized bench for axi_rr_master_scheduler against a queue-based reference model.
module tb_axi_rr_master_scheduler;

  localparam int N = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] MASTER_WR_ADDR_VALID = '0;
  logic [3:0] MASTER_RD_ADDR_VALID = '0;
  logic       BUS_WR_ADDR_READY = 1'b0;
  logic       BUS_WR_DATA_VALID = 1'b0;
  logic       BUS_WR_DATA_READY = 1'b0;
  logic       BUS_WR_DATA_LAST = 1'b0;
  logic       BUS_RD_ADDR_READY = 1'b0;
  logic [1:0] wr_addr_master_sel;
  logic       wr_addr_grant;
  logic [1:0] wr_data_master_sel;
  logic       wr_data_grant;
  logic [1:0] rd_addr_master_sel;
  logic       rd_addr_grant;
  logic       wq_full;

  always #5 clk = ~clk;

  axi_rr_master_scheduler #(
    .M_WIDTH(2),
    .WQ_AW  (2)
  ) u_dut (
    .clk                 (clk),
    .rstn                (rstn),
    .MASTER_WR_ADDR_VALID(MASTER_WR_ADDR_VALID),
    .MASTER_RD_ADDR_VALID(MASTER_RD_ADDR_VALID),
    .BUS_WR_ADDR_READY   (BUS_WR_ADDR_READY),
    .BUS_WR_DATA_VALID   (BUS_WR_DATA_VALID),
    .BUS_WR_DATA_READY   (BUS_WR_DATA_READY),
    .BUS_WR_DATA_LAST    (BUS_WR_DATA_LAST),
    .BUS_RD_ADDR_READY   (BUS_RD_ADDR_READY),
    .wr_addr_master_sel  (wr_addr_master_sel),
    .wr_addr_grant       (wr_addr_grant),
    .wr_data_master_sel  (wr_data_master_sel),
    .wr_data_grant       (wr_data_grant),
    .rd_addr_master_sel  (rd_addr_master_sel),
    .rd_addr_grant       (rd_addr_grant),
    .wq_full             (wq_full)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a grant is "busy + who", and the W FIFO is a plain queue.
  bit m_aw_busy, m_ar_busy;
  int m_aw_sel, m_ar_sel, m_aw_ptr, m_ar_ptr;
  int m_wq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_ref(input logic [3:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_aw_busy = 0; m_ar_busy = 0;
    m_aw_sel = 0; m_ar_sel = 0; m_aw_ptr = 0; m_ar_ptr = 0;
    m_wq.delete();
  endtask

  task automatic model_step(input logic [3:0] awv, input logic [3:0] arv, input logic awr,
                            input logic arr, input logic wv, input logic wr, input logic wl);
    int  sz;
    bit  full, aw_hs, ar_hs, pop;
    sz    = m_wq.size();
    full  = (sz == D);
    aw_hs = m_aw_busy && awv[m_aw_sel] && awr;
    ar_hs = m_ar_busy && arv[m_ar_sel] && arr;
    pop   = wv && wr && wl && (sz != 0);
    if (pop) void'(m_wq.pop_front());
    if (aw_hs) m_wq.push_back(m_aw_sel);
    if (!m_aw_busy) begin
      if (awv != 0 && !full) begin m_aw_sel = rr_ref(awv, m_aw_ptr); m_aw_busy = 1; end
    end else if (aw_hs) begin
      m_aw_ptr = (m_aw_sel + 1) % N; m_aw_busy = 0;
    end
    if (!m_ar_busy) begin
      if (arv != 0) begin m_ar_sel = rr_ref(arv, m_ar_ptr); m_ar_busy = 1; end
    end else if (ar_hs) begin
      m_ar_ptr = (m_ar_sel + 1) % N; m_ar_busy = 0;
    end
  endtask

  task automatic check_all();
    chk("aw_grant", 32'(wr_addr_grant), 32'(m_aw_busy));
    chk("aw_sel", 32'(wr_addr_master_sel), m_aw_sel);
    chk("ar_grant", 32'(rd_addr_grant), 32'(m_ar_busy));
    chk("ar_sel", 32'(rd_addr_master_sel), m_ar_sel);
    chk("w_grant", 32'(wr_data_grant), 32'(m_wq.size() != 0));
    chk("wq_full", 32'(wq_full), 32'(m_wq.size() == D));
    if (m_wq.size() != 0) chk("w_sel", 32'(wr_data_master_sel), m_wq[0]);
  endtask

  // Called on a falling edge: drive, advance the model, clock, check on next falling edge.
  task automatic cycle(input logic [3:0] awv, input logic [3:0] arv, input logic awr,
                       input logic arr, input logic wv, input logic wr, input logic wl);
    MASTER_WR_ADDR_VALID = awv;
    MASTER_RD_ADDR_VALID = arv;
    BUS_WR_ADDR_READY    = awr;
    BUS_RD_ADDR_READY    = arr;
    BUS_WR_DATA_VALID    = wv;
    BUS_WR_DATA_READY    = wr;
    BUS_WR_DATA_LAST     = wl;
    model_step(awv, arv, awr, arr, wv, wr, wl);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    MASTER_WR_ADDR_VALID = '0; MASTER_RD_ADDR_VALID = '0;
    BUS_WR_ADDR_READY = 0; BUS_RD_ADDR_READY = 0;
    BUS_WR_DATA_VALID = 0; BUS_WR_DATA_READY = 0; BUS_WR_DATA_LAST = 0;
    #1;
    chk("rst_aw_grant", 32'(wr_addr_grant), 0);
    chk("rst_aw_sel", 32'(wr_addr_master_sel), 0);
    chk("rst_ar_grant", 32'(rd_addr_grant), 0);
    chk("rst_ar_sel", 32'(rd_addr_master_sel), 0);
    chk("rst_w_grant", 32'(wr_data_grant), 0);
    chk("rst_w_sel", 32'(wr_data_master_sel), 0);
    chk("rst_wq_full", 32'(wq_full), 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    check_all();
  endtask

  initial begin
    model_reset();

    // Rotation among masters 1 and 3.
    do_reset();
    cycle(4'b1010, 4'b0000, 1, 0, 0, 0, 0);
    chk("rot_first_grant", 32'(wr_addr_grant), 1);
    chk("rot_first_sel", 32'(wr_addr_master_sel), 1);
    cycle(4'b1010, 4'b0000, 1, 0, 0, 0, 0);
    chk("rot_idle_gap", 32'(wr_addr_grant), 0);
    cycle(4'b1010, 4'b0000, 1, 0, 0, 0, 0);
    chk("rot_second_sel", 32'(wr_addr_master_sel), 3);
    cycle(4'b1010, 4'b0000, 1, 0, 0, 0, 0);
    cycle(4'b1010, 4'b0000, 1, 0, 0, 0, 0);
    chk("rot_third_sel", 32'(wr_addr_master_sel), 1);

    // AR fairness with all valid; AW fills the W FIFO in parallel.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(4'b1111, 4'b1111, 1, 1, 0, 0, 0);
      chk("ar_pulse", 32'(rd_addr_grant), 32'((k % 2) == 0));
      if ((k % 2) == 0) chk("ar_rot_sel", 32'(rd_addr_master_sel), (k / 2) % 4);
    end
    chk("full_set", 32'(wq_full), 1);
    chk("full_blocks", 32'(wr_addr_grant), 0);
    cycle(4'b0001, 4'b0000, 1, 0, 0, 0, 0);
    chk("full_no_grant", 32'(wr_addr_grant), 0);
    cycle(4'b0001, 4'b0000, 1, 0, 1, 1, 1);
    chk("pop_unfull", 32'(wq_full), 0);
    chk("pop_head", 32'(wr_data_master_sel), 1);
    cycle(4'b0001, 4'b0000, 0, 0, 0, 0, 0);
    chk("after_full_grant", 32'(wr_addr_grant), 1);
    chk("after_full_sel", 32'(wr_addr_master_sel), 0);

    // Grant to master 2 held while READY is low, then master 0 next.
    do_reset();
    cycle(4'b0010, 4'b0000, 1, 0, 0, 0, 0);
    cycle(4'b0010, 4'b0000, 1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cycle(4'b0101, 4'b0000, 0, 0, 0, 0, 0);
      chk("hold_sel", 32'(wr_addr_master_sel), 2);
    end
    cycle(4'b0101, 4'b0000, 1, 0, 0, 0, 0);
    cycle(4'b0101, 4'b0000, 1, 0, 0, 0, 0);
    chk("hold_next_sel", 32'(wr_addr_master_sel), 0);

    // Simultaneous push and pop with one entry.
    do_reset();
    cycle(4'b0100, 4'b0000, 1, 0, 0, 0, 0);
    cycle(4'b0100, 4'b0000, 1, 0, 0, 0, 0);
    cycle(4'b1000, 4'b0000, 0, 0, 0, 0, 0);
    cycle(4'b1000, 4'b0000, 1, 0, 1, 1, 1);
    chk("pushpop_grant", 32'(wr_data_grant), 1);
    chk("pushpop_head", 32'(wr_data_master_sel), 3);

    // Reset mid-traffic: two FIFO entries and an AR grant pending.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(4'b0011, 4'b0100, 1, 0, 0, 0, 0);
    chk("pre_rst_ar", 32'(rd_addr_grant), 1);
    do_reset();
    cycle(4'b1111, 4'b1111, 1, 1, 0, 0, 0);
    chk("post_rst_aw", 32'(wr_addr_master_sel), 0);
    chk("post_rst_ar", 32'(rd_addr_master_sel), 0);

    // Random traffic.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rr_master_scheduler.md
Name: axi_rr_master_scheduler

Overview:
- Round-robin master scheduler for the AXI4 interconnect. It replaces fixed-priority master selection on the write-address (AW) and read-address (AR) channels.
- Grants are registered. A grant is held until its address handshake completes.
- Each accepted AW grant is queued in an in-order grant FIFO, which steers the write-data (W) channel burst by burst until WLAST.
- Sits between the master-side VALID vectors and the crossbar muxes: it drives the master select lines and the grant-valid gates.

Parameters:
- M_WIDTH, 2, log2 of master count; N = 2**M_WIDTH masters.
- WQ_AW, 2, log2 of W-grant FIFO depth; depth D = 2**WQ_AW outstanding AW-accepted bursts whose data is not yet complete.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- MASTER_WR_ADDR_VALID  in  N  per-master AWVALID.
- MASTER_RD_ADDR_VALID  in  N  per-master ARVALID.
- BUS_WR_ADDR_READY  in  1  slave-side AWREADY after the crossbar.
- BUS_WR_DATA_VALID  in  1  muxed WVALID.
- BUS_WR_DATA_READY  in  1  slave-side WREADY.
- BUS_WR_DATA_LAST  in  1  muxed WLAST.
- BUS_RD_ADDR_READY  in  1  slave-side ARREADY.
- wr_addr_master_sel  out  M_WIDTH  AW mux select.
- wr_addr_grant  out  1  AW grant active; the crossbar forwards AWVALID/AWREADY only while this is 1.
- wr_data_master_sel  out  M_WIDTH  W mux select (FIFO head).
- wr_data_grant  out  1  W FIFO non-empty; the crossbar forwards WVALID/WREADY only while this is 1.
- rd_addr_master_sel  out  M_WIDTH  AR mux select.
- rd_addr_grant  out  1  AR grant active.
- wq_full  out  1  W-grant FIFO full (status).

Behaviour:
- Reset (rstn=0, async), all outputs 0:
  - both arbiter FSMs go to IDLE;
  - both round-robin pointers are 0;
  - FIFO read/write pointers are 0 and count is 0.
- AW arbiter FSM states: IDLE, GRANT.
  - IDLE → GRANT: when any MASTER_WR_ADDR_VALID bit is set and wq_full=0.
    - On that edge the winner is registered: the first set bit scanning from wr_ptr upward, wrapping modulo N.
    - wr_addr_grant=1 and wr_addr_master_sel=winner on the next cycle (1-cycle grant latency).
  - In IDLE, wr_addr_grant=0 and wr_addr_master_sel holds its last value.
  - GRANT → IDLE: when MASTER_WR_ADDR_VALID[sel] & BUS_WR_ADDR_READY (handshake).
    - On that edge: push sel into the W FIFO, set wr_ptr = sel+1 mod N, and deassert wr_addr_grant.
    - A new grant therefore needs at least 1 IDLE cycle: maximum rate is one AW handshake per 2 cycles.
  - The GRANT state is held indefinitely while the handshake has not occurred, even if the granted master drops VALID (AXI protocol violation; not re-arbitrated).
- AR arbiter: identical FSM using rd_ptr, MASTER_RD_ADDR_VALID and BUS_RD_ADDR_READY. It has no FIFO and no full gate. The AW and AR arbiters are fully independent.
- W-grant FIFO (depth D, width M_WIDTH):
  - Outputs: wr_data_master_sel = head entry; wr_data_grant = (count != 0).
  - Pop: BUS_WR_DATA_VALID & BUS_WR_DATA_READY & BUS_WR_DATA_LAST & wr_data_grant.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push on empty: the entry becomes visible on the next cycle. W data is never routed before its AW handshake.
  - wq_full = (count == D). The AW arbiter does not leave IDLE while full, so a push can never occur when full.
  - A pop while empty is ignored.
  - count is M_WIDTH... sized WQ_AW+1 bits. Pointers wrap modulo D.
- Round-robin fairness: with all N requesters continuously valid and the slave always ready, grants rotate 0,1,…,N-1,0.

Decomposition:
- Package axi_sched_pkg:
  - typedef arb_state_t {IDLE, GRANT};
  - function rr_pick(req vector, pointer) returning the winner index and a found flag.
- Sub-module axi_rr_addr_arb: the FSM plus pointer. It is instantiated twice (AW with a full-gate input; AR with the gate tied to 0).
- The FIFO is inline in the top module.

Test Plan:
- Reset, then MASTER_WR_ADDR_VALID=4'b1010 with READY=1 → first grant sel=1 at cycle +1; after handshake, next grant sel=3; then sel=1 (rotation).
- All four AR VALIDs held high, ARREADY=1 → rd_addr_master_sel sequence 0,1,2,3,0 with rd_addr_grant pulsing 1 cycle on, 1 cycle off.
- AWREADY held 0 for 5 cycles with master 2 granted while master 0 is also valid → sel stays 2 for all 5 cycles; after the handshake the next grant is 0.
- Four AW handshakes (masters 0,1,2,3) with WREADY=0 → wq_full=1; a fifth request from master 0 is not granted. One WLAST handshake → wq_full=0, wr_data_master_sel=1, master 0 granted.
- Simultaneous AW push (master 3) and WLAST pop with count=1 (head=2) → next cycle count=1, wr_data_master_sel=3.
- rstn asserted mid-burst with the FIFO holding 2 entries and AR in GRANT → all outputs 0 immediately; after release, arbitration restarts with pointers at 0.
